// File: rtl/debug_pkg.sv
// Shared definitions for the debug display scanner family.
//   - mode encodings for the index source selector
//   - freeze FSM state type and state constants
//   - default word shown for an out-of-range channel index
package debug_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;

  typedef logic [0:0] frz_state_t;
  localparam frz_state_t ST_LIVE   = 1'b0;
  localparam frz_state_t ST_FROZEN = 1'b1;

  localparam logic [31:0] DEF_ERR_WORD = 32'h0000DEDE;

endpackage

// File: rtl/debug_display_scanner_if.sv
// Bundle of the scanner's data/control signals.
//   master : debug source side (drives channels, switches, buttons)
//   slave  : the scanner itself (drives display_word, cur_ch, frozen, sel_err)
interface debug_display_scanner_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 32,
  parameter int SEL_W  = 6
);
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [SEL_W-1:0]         sel;
  logic [1:0]               mode;
  logic                     step_btn;
  logic                     freeze_req;
  logic                     override_en;
  logic [DATA_W-1:0]        override_data;
  logic [DATA_W-1:0]        display_word;
  logic [SEL_W-1:0]         cur_ch;
  logic                     frozen;
  logic                     sel_err;

  modport master (
    output ch_data, sel, mode, step_btn, freeze_req, override_en, override_data,
    input  display_word, cur_ch, frozen, sel_err
  );

  modport slave (
    input  ch_data, sel, mode, step_btn, freeze_req, override_en, override_data,
    output display_word, cur_ch, frozen, sel_err
  );
endinterface

// File: rtl/debug_step_sync.sv
// Pushbutton conditioner: 2-flop synchroniser for an active-low asynchronous
// button followed by a falling-edge (press) detector.
//   clock   : system clock
//   reset_n : asynchronous active-low reset (flops idle high)
//   btn_n   : raw active-low button
//   fall    : one-cycle pulse per press
module debug_step_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_n,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic sync_d_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      sync_d_q <= 1'b1;
    end else begin
      meta_q   <= btn_n;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
    end
  end

  // Edge taken only from the settled flops, never from the metastable one.
  assign fall = sync_d_q & ~sync_q;

endmodule

// File: rtl/debug_display_scanner.sv
// Clocked debug display mux with manual / timed-scan / step channel selection,
// a coherent freeze snapshot of all channels and a register-file override.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : ch_data, sel, mode, step_btn, freeze_req, override_en,
//                    override_data in; display_word, cur_ch, frozen, sel_err out
module debug_display_scanner
  import debug_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_CH   = 32,
  parameter int                SEL_W    = 6,
  parameter int                DWELL    = 50000000,
  parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(DEF_ERR_WORD)
) (
  input logic                 clock,
  input logic                 reset_n,
  debug_display_scanner_if.slave bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [1:0]               mode_q;
  logic [CNT_W-1:0]         cnt_q, cnt_nxt;
  logic [SEL_W-1:0]         cur_ch_q, idx_nxt;
  frz_state_t               state_q;
  logic [NUM_CH*DATA_W-1:0] snap_q;
  logic [DATA_W-1:0]        display_p1, display_nxt, word;
  logic                     sel_err_p1, idx_err;
  logic                     step_fall, mode_chg, use_snap;
  logic [1:0]               eff_mode;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    if (int'(i) >= NUM_CH - 1) return '0;
    return i + SEL_W'(1);
  endfunction

  debug_step_sync u_step (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_n   (bus.step_btn),
    .fall    (step_fall)
  );

  assign eff_mode = (bus.mode == 2'b11) ? MODE_MANUAL : bus.mode;
  assign mode_chg = (bus.mode != mode_q);

  // Next index: cur_ch is loaded with this, and the display word is read with
  // it in the same edge so display_word and cur_ch always agree.
  always_comb begin
    cnt_nxt = '0;
    idx_nxt = cur_ch_q;
    case (eff_mode)
      MODE_SCAN: begin
        if (mode_chg) begin
          cnt_nxt = '0;
        end else if (cnt_q == CNT_W'(DWELL - 1)) begin
          cnt_nxt = '0;
          idx_nxt = wrap_inc(cur_ch_q);
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      MODE_STEP: begin
        if (step_fall) idx_nxt = wrap_inc(cur_ch_q);
      end
      default: idx_nxt = bus.sel;
    endcase
  end

  // In the capture cycle live data equals what the snapshot receives, so the
  // buffer is only needed once the FSM is already FROZEN and still requested.
  assign use_snap = (state_q == ST_FROZEN) && bus.freeze_req;
  assign idx_err  = (int'(idx_nxt) >= NUM_CH);

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(idx_nxt) == k)
        word = use_snap ? snap_q[k*DATA_W +: DATA_W] : bus.ch_data[k*DATA_W +: DATA_W];
    end
    if (bus.override_en) display_nxt = bus.override_data;
    else if (idx_err)    display_nxt = ERR_WORD;
    else                 display_nxt = word;
  end

  // ---- stage p1: registered index, freeze state, snapshot and display ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_MANUAL;
      cnt_q      <= '0;
      cur_ch_q   <= '0;
      state_q    <= ST_LIVE;
      snap_q     <= '0;
      display_p1 <= '0;
      sel_err_p1 <= 1'b0;
    end else begin
      mode_q     <= bus.mode;
      cnt_q      <= cnt_nxt;
      cur_ch_q   <= idx_nxt;
      state_q    <= bus.freeze_req ? ST_FROZEN : ST_LIVE;
      if ((state_q == ST_LIVE) && bus.freeze_req) snap_q <= bus.ch_data;
      display_p1 <= display_nxt;
      sel_err_p1 <= idx_err;
    end
  end

  assign bus.display_word = display_p1;
  assign bus.cur_ch       = cur_ch_q;
  assign bus.frozen       = (state_q == ST_FROZEN);
  assign bus.sel_err      = sel_err_p1;

endmodule

// File: tb/tb_debug_display_scanner.sv
module tb_debug_display_scanner;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 27;
  localparam int SEL_W  = 6;
  localparam int DWELL  = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [DATA_W-1:0] chv [NUM_CH];
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  debug_display_scanner_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

  debug_display_scanner #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W),
    .DWELL  (DWELL)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always_comb begin
    bus.ch_data = '0;
    for (int k = 0; k < NUM_CH; k++) bus.ch_data[k*DATA_W +: DATA_W] = chv[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) chv[k] = 32'hA5000000 | k;
    chv[3] = 32'h12345678;
    chv[5] = 32'hAAAA0000;
    bus.sel = '0;
    bus.mode = 2'b00;
    bus.step_btn = 1'b1;
    bus.freeze_req = 1'b0;
    bus.override_en = 1'b0;
    bus.override_data = '0;

    // reset state
    cyc(3);
    chk("rst_display", bus.display_word, 32'h0);
    chk("rst_cur_ch", 32'(bus.cur_ch), 32'd0);
    chk("rst_frozen", 32'(bus.frozen), 32'd0);
    chk("rst_sel_err", 32'(bus.sel_err), 32'd0);
    reset_n = 1'b1;

    // manual select, one-clock latency
    bus.sel = 6'd3;
    cyc(1);
    chk("man_display", bus.display_word, 32'h12345678);
    chk("man_cur_ch", 32'(bus.cur_ch), 32'd3);
    chk("man_sel_err", 32'(bus.sel_err), 32'd0);

    // out-of-range index
    bus.sel = 6'd40;
    cyc(1);
    chk("oor_display", bus.display_word, 32'h0000DEDE);
    chk("oor_sel_err", 32'(bus.sel_err), 32'd1);
    bus.sel = 6'd7;
    cyc(1);
    chk("man7_display", bus.display_word, 32'hA5000007);
    chk("man7_sel_err", 32'(bus.sel_err), 32'd0);

    // scan from NUM_CH-2: entry edge holds, then 4-cycle dwell per channel
    bus.sel = 6'(NUM_CH - 2);
    cyc(1);
    bus.mode = 2'b01;
    cyc(1);
    chk("scan_entry", 32'(bus.cur_ch), 32'(NUM_CH - 2));
    cyc(3);
    chk("scan_hold", 32'(bus.cur_ch), 32'(NUM_CH - 2));
    cyc(1);
    chk("scan_last", 32'(bus.cur_ch), 32'(NUM_CH - 1));
    cyc(3);
    chk("scan_last_hold", 32'(bus.cur_ch), 32'(NUM_CH - 1));
    cyc(1);
    chk("scan_wrap", 32'(bus.cur_ch), 32'd0);
    chk("scan_wrap_disp", bus.display_word, 32'hA5000000);
    cyc(4);
    chk("scan_one", 32'(bus.cur_ch), 32'd1);

    // override during scan
    bus.override_en = 1'b1;
    bus.override_data = 32'hCAFEF00D;
    cyc(1);
    chk("ovr_display", bus.display_word, 32'hCAFEF00D);
    cyc(3);
    chk("ovr_cur_ch", 32'(bus.cur_ch), 32'd2);
    chk("ovr_display2", bus.display_word, 32'hCAFEF00D);
    bus.override_en = 1'b0;

    // step: three presses of 5 cycles each
    bus.mode = 2'b00;
    bus.sel = 6'd0;
    cyc(1);
    chk("step_start", 32'(bus.cur_ch), 32'd0);
    bus.mode = 2'b10;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      bus.step_btn = 1'b0;
      cyc(5);
      bus.step_btn = 1'b1;
      cyc(5);
      chk("step_count", 32'(bus.cur_ch), 32'(i + 1));
    end
    chk("step_display", bus.display_word, 32'h12345678);

    // step edge coinciding with switch to manual is discarded
    bus.step_btn = 1'b0;
    cyc(2);
    bus.mode = 2'b00;
    bus.sel = 6'd10;
    cyc(1);
    chk("step_vs_manual", 32'(bus.cur_ch), 32'd10);
    bus.step_btn = 1'b1;
    cyc(5);
    bus.mode = 2'b10;
    cyc(3);
    chk("step_resume", 32'(bus.cur_ch), 32'd10);

    // freeze snapshot
    bus.mode = 2'b00;
    bus.sel = 6'd5;
    cyc(1);
    chk("frz_pre_disp", bus.display_word, 32'hAAAA0000);
    chk("frz_pre_flag", 32'(bus.frozen), 32'd0);
    bus.freeze_req = 1'b1;
    cyc(1);
    chk("frz_flag", 32'(bus.frozen), 32'd1);
    chv[5] = 32'h5555FFFF;
    cyc(1);
    chk("frz_hold_disp", bus.display_word, 32'hAAAA0000);
    chk("frz_hold_flag", 32'(bus.frozen), 32'd1);
    bus.freeze_req = 1'b0;
    cyc(1);
    chk("frz_rel_disp", bus.display_word, 32'h5555FFFF);
    chk("frz_rel_flag", 32'(bus.frozen), 32'd0);

    // asynchronous reset mid-freeze
    bus.freeze_req = 1'b1;
    cyc(2);
    chk("rf_frozen", 32'(bus.frozen), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rf_display", bus.display_word, 32'h0);
    chk("rf_cur_ch", 32'(bus.cur_ch), 32'd0);
    chk("rf_frozen0", 32'(bus.frozen), 32'd0);
    chk("rf_sel_err", 32'(bus.sel_err), 32'd0);
    bus.freeze_req = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    chk("post_rst_disp", bus.display_word, 32'h5555FFFF);
    chk("post_rst_flag", 32'(bus.frozen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
